// File: rtl/wb_stage.sv
// Writeback stage: registered scalar register-file writes, plus the LDB engine that
// gathers a streamed bitmap word by word and commits it to a bitmap register in one cycle.
module wb_stage #(
   parameter int WORD_W = 16,
   parameter int BM_W   = 1536,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_mem_to_reg,
   input  logic [WORD_W-1:0] wb_alu_result,
   input  logic [WORD_W-1:0] wb_mem_data,
   input  logic              wb_ldb,
   input  logic [1:0]        wb_bm_addr,
   input  logic [1:0]        wb_bm_half,
   input  logic              ldb_word_valid,
   input  logic [WORD_W-1:0] ldb_word,
   output logic              ldb_word_ready,
   output logic              stall,
   output logic [REG_AW-1:0] write_reg_addr,
   output logic [WORD_W-1:0] write_reg_data,
   output logic              write_reg_en,
   output logic [1:0]        write_bm_addr,
   output logic [BM_W-1:0]   write_bm_data,
   output logic [1:0]        write_bm_en
);

   localparam int BM_WORDS = BM_W / WORD_W;
   localparam int CNT_W    = $clog2(BM_WORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        addr_q;
   logic [1:0]        mask_q;
   logic [WORD_W-1:0] buf_q [BM_WORDS];
   logic              accept;
   logic              last_word;

   assign stall          = (state_q != IDLE);
   assign ldb_word_ready = (state_q == LOAD);
   assign accept         = (state_q == LOAD) && ldb_word_valid;

   // A low-half load stops at the midpoint; full and high-half loads run to the top word.
   assign last_word = (mask_q == 2'b01) ? (cnt_q == CNT_W'(BM_WORDS/2 - 1))
                                        : (cnt_q == CNT_W'(BM_WORDS - 1));

   generate
      for (genvar gi = 0; gi < BM_WORDS; gi++) begin : g_pack
         assign write_bm_data[gi*WORD_W +: WORD_W] = buf_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         addr_q         <= '0;
         mask_q         <= '0;
         write_reg_en   <= 1'b0;
         write_reg_addr <= '0;
         write_reg_data <= '0;
         write_bm_en    <= '0;
         write_bm_addr  <= '0;
         for (int i = 0; i < BM_WORDS; i++) buf_q[i] <= '0;
      end else begin
         write_reg_en <= wb_valid && wb_reg_write && !stall;
         if (wb_valid && wb_reg_write && !stall) begin
            write_reg_addr <= wb_rd;
            write_reg_data <= wb_mem_to_reg ? wb_mem_data : wb_alu_result;
         end
         write_bm_en <= '0;

         case (state_q)
            IDLE: begin
               if (wb_valid && wb_ldb) begin
                  state_q <= LOAD;
                  addr_q  <= wb_bm_addr;
                  mask_q  <= (wb_bm_half == 2'b00) ? 2'b11 : wb_bm_half;
                  cnt_q   <= (wb_bm_half == 2'b10) ? CNT_W'(BM_WORDS/2) : '0;
                  for (int i = 0; i < BM_WORDS; i++) buf_q[i] <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  buf_q[cnt_q] <= ldb_word;
                  cnt_q        <= cnt_q + 1'b1;
                  // Strobe and address are loaded here so they are valid throughout COMMIT.
                  if (last_word) begin
                     state_q       <= COMMIT;
                     write_bm_en   <= mask_q;
                     write_bm_addr <= addr_q;
                  end
               end
            end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: scalar writeback, full / half / gapped bitmap loads,
// reset during a load, and a combined scalar + LDB instruction.
module tb_wb_stage;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wb_valid, wb_reg_write, wb_mem_to_reg, wb_ldb;
   logic [3:0]    wb_rd;
   logic [15:0]   wb_alu_result, wb_mem_data, ldb_word;
   logic [1:0]    wb_bm_addr, wb_bm_half;
   logic          ldb_word_valid;
   logic          ldb_word_ready, stall, write_reg_en;
   logic [3:0]    write_reg_addr;
   logic [15:0]   write_reg_data;
   logic [1:0]    write_bm_addr, write_bm_en;
   logic [1535:0] write_bm_data;

   logic [1535:0] exp_bm;
   int            checks = 0;
   int            errors = 0;
   int            stall_cycles;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result),
      .wb_mem_data(wb_mem_data), .wb_ldb(wb_ldb), .wb_bm_addr(wb_bm_addr),
      .wb_bm_half(wb_bm_half), .ldb_word_valid(ldb_word_valid), .ldb_word(ldb_word),
      .ldb_word_ready(ldb_word_ready), .stall(stall),
      .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
      .write_reg_en(write_reg_en), .write_bm_addr(write_bm_addr),
      .write_bm_data(write_bm_data), .write_bm_en(write_bm_en)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bm(input string tag);
      check_val({tag, " bm_lo"}, write_bm_data[767:0], exp_bm[767:0]);
      check_val({tag, " bm_hi"}, write_bm_data[1535:768], exp_bm[1535:768]);
   endtask

   task automatic start_ldb(input logic [1:0] addr, input logic [1:0] half);
      wb_valid = 1'b1; wb_ldb = 1'b1; wb_bm_addr = addr; wb_bm_half = half;
      tick();
      wb_valid = 1'b0; wb_ldb = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0; wb_ldb = 0;
      wb_rd = 0; wb_alu_result = 0; wb_mem_data = 0; ldb_word = 0;
      wb_bm_addr = 0; wb_bm_half = 0; ldb_word_valid = 0;
      exp_bm = '0;
      tick(); tick();
      check_val("rst reg_en", 768'(write_reg_en), 768'(0));
      check_val("rst stall", 768'(stall), 768'(0));
      check_val("rst ready", 768'(ldb_word_ready), 768'(0));
      check_val("rst bm_en", 768'(write_bm_en), 768'(0));
      check_bm("rst");
      rst_n = 1'b1;
      tick();

      // ALU writeback
      wb_valid = 1; wb_reg_write = 1; wb_rd = 5; wb_mem_to_reg = 0; wb_alu_result = 16'h1234;
      tick();
      wb_valid = 0; wb_reg_write = 0;
      check_val("alu en", 768'(write_reg_en), 768'(1));
      check_val("alu addr", 768'(write_reg_addr), 768'(5));
      check_val("alu data", 768'(write_reg_data), 768'(16'h1234));
      tick();
      check_val("alu en drop", 768'(write_reg_en), 768'(0));
      check_val("alu addr hold", 768'(write_reg_addr), 768'(5));

      // Load writeback
      wb_valid = 1; wb_reg_write = 1; wb_rd = 15; wb_mem_to_reg = 1;
      wb_mem_data = 16'hBEEF; wb_alu_result = 16'h0001;
      tick();
      wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0;
      check_val("ld en", 768'(write_reg_en), 768'(1));
      check_val("ld addr", 768'(write_reg_addr), 768'(15));
      check_val("ld data", 768'(write_reg_data), 768'(16'hBEEF));
      tick();

      // Full LDB, continuous words
      start_ldb(2'd2, 2'b11);
      check_val("full stall", 768'(stall), 768'(1));
      check_val("full ready", 768'(ldb_word_ready), 768'(1));
      exp_bm = '0;
      stall_cycles = 0;
      for (int k = 0; k < 96; k++) begin
         if (stall) stall_cycles++;
         ldb_word_valid = 1; ldb_word = 16'(k);
         exp_bm[16*k +: 16] = 16'(k);
         tick();
      end
      ldb_word_valid = 0;
      if (stall) stall_cycles++;
      check_val("full bm_en", 768'(write_bm_en), 768'(2'b11));
      check_val("full bm_addr", 768'(write_bm_addr), 768'(2));
      check_val("full commit ready", 768'(ldb_word_ready), 768'(0));
      check_bm("full");
      tick();
      check_val("full stall drop", 768'(stall), 768'(0));
      check_val("full bm_en drop", 768'(write_bm_en), 768'(0));
      check_val("full stall cycles", 768'(stall_cycles), 768'(97));
      check_bm("full hold");

      // High half with gaps in valid
      start_ldb(2'd1, 2'b10);
      exp_bm = '0;
      for (int i = 0; i < 48; i++) begin
         ldb_word_valid = 0; ldb_word = 16'hDEAD;
         tick();
         ldb_word_valid = 1; ldb_word = 16'hA000 + 16'(i);
         exp_bm[768 + 16*i +: 16] = 16'hA000 + 16'(i);
         tick();
      end
      ldb_word_valid = 0;
      check_val("high bm_en", 768'(write_bm_en), 768'(2'b10));
      check_val("high bm_addr", 768'(write_bm_addr), 768'(1));
      check_bm("high");
      tick();
      check_val("high stall drop", 768'(stall), 768'(0));

      // Reset in the middle of a load
      start_ldb(2'd3, 2'b11);
      for (int k = 0; k < 30; k++) begin
         ldb_word_valid = 1; ldb_word = 16'hFFFF;
         tick();
      end
      ldb_word_valid = 0;
      rst_n = 1'b0;
      #1;
      exp_bm = '0;
      check_val("mid rst stall", 768'(stall), 768'(0));
      check_val("mid rst ready", 768'(ldb_word_ready), 768'(0));
      check_val("mid rst bm_en", 768'(write_bm_en), 768'(0));
      check_val("mid rst bm_addr", 768'(write_bm_addr), 768'(0));
      check_val("mid rst reg_data", 768'(write_reg_data), 768'(0));
      check_bm("mid rst");
      tick();
      rst_n = 1'b1;
      tick();
      check_val("post rst bm_en", 768'(write_bm_en), 768'(0));
      check_val("post rst stall", 768'(stall), 768'(0));
      start_ldb(2'd0, 2'b00);
      for (int k = 0; k < 96; k++) begin
         ldb_word_valid = 1; ldb_word = 16'(k) ^ 16'h5555;
         exp_bm[16*k +: 16] = 16'(k) ^ 16'h5555;
         tick();
      end
      ldb_word_valid = 0;
      check_val("relaunch bm_en", 768'(write_bm_en), 768'(2'b11));
      check_val("relaunch bm_addr", 768'(write_bm_addr), 768'(0));
      check_bm("relaunch");
      tick();

      // Combined scalar write + low-half LDB; wb_valid held high during the stall
      wb_valid = 1; wb_reg_write = 1; wb_ldb = 1; wb_rd = 3; wb_alu_result = 16'd7;
      wb_bm_addr = 2'd1; wb_bm_half = 2'b01;
      tick();
      wb_ldb = 0; wb_rd = 9; wb_alu_result = 16'h0055;
      check_val("combo reg_en", 768'(write_reg_en), 768'(1));
      check_val("combo reg_addr", 768'(write_reg_addr), 768'(3));
      check_val("combo reg_data", 768'(write_reg_data), 768'(7));
      check_val("combo stall", 768'(stall), 768'(1));
      exp_bm = '0;
      for (int i = 0; i < 48; i++) begin
         ldb_word_valid = 1; ldb_word = 16'h0100 + 16'(i);
         exp_bm[16*i +: 16] = 16'h0100 + 16'(i);
         tick();
         if (i == 0) check_val("combo no reg write", 768'(write_reg_en), 768'(0));
      end
      ldb_word_valid = 0;
      check_val("combo bm_en", 768'(write_bm_en), 768'(2'b01));
      check_val("combo bm_addr", 768'(write_bm_addr), 768'(1));
      check_val("combo commit reg_en", 768'(write_reg_en), 768'(0));
      check_bm("combo");
      wb_valid = 0; wb_reg_write = 0;
      tick();
      check_val("combo end reg_en", 768'(write_reg_en), 768'(0));
      check_val("combo end reg_addr", 768'(write_reg_addr), 768'(3));
      check_val("combo end stall", 768'(stall), 768'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
